id_ex_pipe_stage: RTL and testbench

Parametrised ID/EX pipeline stage with a valid/ready handshake and a 2-entry skid buffer. Upstream (ID) can be back-pressured and downstream (EX) can stall without losing instructions.
Adds synchronous flush (branch/jump squash) and bubble-gated control fields.
Extracts rs/rt/rd from the instruction word at parametrised bit positions.
Sits between the decode/register-file stage and the execute stage.

---
 rtl/id_ex_pipe_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID/EX pipeline register with a valid/ready handshake and a
// 2-entry skid buffer (main + skid). Supports a synchronous flush and gates the
// control fields to zero on bubbles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 squash all held entries; blocks input this cycle
//   in_valid/in_ready     upstream (ID) handshake
//   *_in                  PC+4, read data, immediate, instruction, WB/M/EX control
//   out_valid/out_ready   downstream (EX) handshake
//   *_out                 main-register contents; rs/rt/rd sliced from instr
//   occupancy             entries held (0..2)
module id_ex_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RS_LSB     = 21,
  parameter int RT_LSB     = 16,
  parameter int RD_LSB     = 11,
  parameter int WB_W       = 2,
  parameter int M_W        = 2,
  parameter int EX_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     pc_plus4_in,
  input  logic [DATA_W-1:0]     rd1_in,
  input  logic [DATA_W-1:0]     rd2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [INSTR_W-1:0]    instr_in,
  input  logic [WB_W-1:0]       wb_in,
  input  logic [M_W-1:0]        m_in,
  input  logic [EX_W-1:0]       ex_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     pc_plus4_out,
  output logic [DATA_W-1:0]     rd1_out,
  output logic [DATA_W-1:0]     rd2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [WB_W-1:0]       wb_out,
  output logic [M_W-1:0]        m_out,
  output logic [EX_W-1:0]       ex_out,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_W-1:0]       wb;
    logic [M_W-1:0]        m;
    logic [EX_W-1:0]       ex;
  } entry_t;

  // Encoding equals occupancy so the count is a direct read of the state.
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2} state_e;

  state_e state_q;
  entry_t main_q, skid_q, in_d;
  logic   in_fire, out_fire;

  // Only the register-specifier slices of the instruction are stored.
  logic   instr_unused;
  assign instr_unused = ^instr_in;

  assign in_d = '{pc:  pc_plus4_in, rd1: rd1_in, rd2: rd2_in, imm: imm_in,
                  rs:  instr_in[RS_LSB +: REG_ADDR_W],
                  rt:  instr_in[RT_LSB +: REG_ADDR_W],
                  rd:  instr_in[RD_LSB +: REG_ADDR_W],
                  wb:  wb_in, m: m_in, ex: ex_in};

  // in_ready is independent of out_ready: a full main register spills to skid.
  assign in_ready  = (state_q != S_SKID) & ~flush;
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // Entries are discarded; register contents are don't-care once empty.
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (in_fire) begin
          main_q  <= in_d;
          state_q <= S_FULL;
        end
        S_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= in_d;
          end else if (in_fire) begin
            skid_q  <= in_d;
            state_q <= S_SKID;
          end else if (out_fire) begin
            state_q <= S_EMPTY;
          end
        end
        S_SKID: if (out_fire) begin
          main_q  <= skid_q;
          state_q <= S_FULL;
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign pc_plus4_out = main_q.pc;
  assign rd1_out      = main_q.rd1;
  assign rd2_out      = main_q.rd2;
  assign imm_out      = main_q.imm;
  assign rs_out       = main_q.rs;
  assign rt_out       = main_q.rt;
  assign rd_out       = main_q.rd;
  // Bubbles must not carry RegWrite/MemWrite/MemRead into EX.
  assign wb_out       = out_valid ? main_q.wb : '0;
  assign m_out        = out_valid ? main_q.m  : '0;
  assign ex_out       = out_valid ? main_q.ex : '0;
  assign occupancy    = state_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed vector table plus a queue scoreboard
// monitor that tracks every accepted entry through to consumption.
module tb_id_ex_pipe_stage;

  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [31:0] pc_plus4_in = 0, rd1_in = 0, rd2_in = 0, imm_in = 0, instr_in = 0;
  logic [1:0]  wb_in = 0, m_in = 0;
  logic [3:0]  ex_in = 0;
  logic [31:0] pc_plus4_out, rd1_out, rd2_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic [1:0]  wb_out, m_out, occupancy;
  logic [3:0]  ex_out;

  int checks = 0, failures = 0, pop_cnt = 0;

  id_ex_pipe_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_plus4_in(pc_plus4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .instr_in(instr_in), .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_plus4_out(pc_plus4_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  wb, m;
    logic [3:0]  ex;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples 3 time units after each negedge, before posedge.
  initial begin
    ent_t act, e;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) q.delete();
      else begin
        chk("occupancy", occupancy, q.size());
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, (q.size() < 2) && !flush);
        if (out_valid) begin
          if (q.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            act = '{pc_plus4_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out,
                    wb_out, m_out, ex_out};
            chk("entry", act, q[0]);
            if (out_ready) begin
              void'(q.pop_front());
              pop_cnt++;
            end
          end
        end else chk("bubble_ctrl", {wb_out, m_out, ex_out}, 0);
        if (flush) q.delete();
        else if (in_valid && in_ready) begin
          e = '{pc_plus4_in, rd1_in, rd2_in, imm_in, instr_in[25:21], instr_in[20:16],
                instr_in[15:11], wb_in, m_in, ex_in};
          q.push_back(e);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [31:0] ins, input logic [1:0] wb, input logic [1:0] m,
                       input logic [3:0] ex);
    @(negedge clk);
    rst_n = r; flush = f; in_valid = iv; out_ready = ordy;
    instr_in = ins; wb_in = wb; m_in = m; ex_in = ex;
    pc_plus4_in = $urandom; rd1_in = $urandom; rd2_in = $urandom; imm_in = $urandom;
    #4;
  endtask

  typedef struct {
    bit r, f, iv, ordy;
    logic [31:0] ins; logic [1:0] wb, m; logic [3:0] ex;
    bit chk_en; int occ; bit ov, ir; logic [1:0] ewb, em;
    bit chk_rs; logic [4:0] ers; bit zero;
  } vec_t;

  function automatic logic [31:0] mk(input logic [4:0] rs);
    return {6'h0, rs, 5'd1, 5'd2, 11'h0};
  endfunction

  vec_t vt[$];

  function automatic void add(bit r, bit f, bit iv, bit ordy, logic [31:0] ins,
                              logic [1:0] wb, logic [1:0] m, logic [3:0] ex, bit ce,
                              int occ, bit ov, bit ir, logic [1:0] ewb, logic [1:0] em,
                              bit crs, logic [4:0] ers, bit zero);
    vec_t v;
    v = '{r, f, iv, ordy, ins, wb, m, ex, ce, occ, ov, ir, ewb, em, crs, ers, zero};
    vt.push_back(v);
  endfunction

  initial begin
    int p0;
    // Expectations describe the stage as seen while the row's inputs are applied.
    //  r f iv or instr          wb     m      ex      ce occ ov ir ewb   em    crs rs zero
    add(0,0,1,1, mk(5'd3),      2'b11, 2'b11, 4'hF,  0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    add(0,0,1,1, mk(5'd3),      2'b11, 2'b11, 4'hF,  1, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1);
    add(1,0,1,1, 32'h012A4020,  2'b10, 2'b00, 4'hC,  1, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1);
    add(1,0,0,1, 0,             2'b00, 2'b00, 4'h0,  1, 1, 1, 1, 2'b10, 2'b00, 1, 9, 0);
    add(1,0,1,0, mk(5'd3),      2'b01, 2'b10, 4'h3,  1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    add(1,0,1,0, mk(5'd5),      2'b11, 2'b01, 4'h5,  1, 1, 1, 1, 2'b01, 2'b10, 1, 3, 0);
    add(1,0,1,0, mk(5'd9),      2'b11, 2'b11, 4'h9,  1, 2, 1, 0, 2'b01, 2'b10, 1, 3, 0);
    add(1,0,0,1, 0,             2'b00, 2'b00, 4'h0,  1, 2, 1, 0, 2'b01, 2'b10, 1, 3, 0);
    add(1,0,0,1, 0,             2'b00, 2'b00, 4'h0,  1, 1, 1, 1, 2'b11, 2'b01, 1, 5, 0);
    add(1,0,1,0, mk(5'd7),      2'b11, 2'b11, 4'h7,  1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    add(1,0,1,0, mk(5'd2),      2'b00, 2'b00, 4'h2,  1, 1, 1, 1, 2'b11, 2'b11, 1, 7, 0);
    add(1,1,1,0, mk(5'd1),      2'b11, 2'b01, 4'h1,  1, 2, 1, 0, 2'b11, 2'b11, 1, 7, 0);
    add(1,0,0,1, 0,             2'b00, 2'b00, 4'h0,  1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    add(1,0,1,1, mk(5'd4),      2'b10, 2'b00, 4'h4,  1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    add(1,0,1,1, mk(5'd6),      2'b01, 2'b10, 4'h6,  1, 1, 1, 1, 2'b10, 2'b00, 1, 4, 0);
    add(1,0,0,1, 0,             2'b00, 2'b00, 4'h0,  1, 1, 1, 1, 2'b01, 2'b10, 1, 6, 0);
    add(1,0,1,0, mk(5'd8),      2'b11, 2'b11, 4'h8,  1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    add(1,0,1,0, mk(5'd10),     2'b10, 2'b10, 4'hA,  1, 1, 1, 1, 2'b11, 2'b11, 1, 8, 0);
    add(0,0,1,0, mk(5'd11),     2'b11, 2'b11, 4'hB,  1, 2, 1, 0, 2'b11, 2'b11, 1, 8, 0);
    add(1,0,0,1, 0,             2'b00, 2'b00, 4'h0,  1, 0, 0, 1, 2'b00, 2'b00, 1, 0, 1);

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].f, vt[i].iv, vt[i].ordy, vt[i].ins, vt[i].wb, vt[i].m, vt[i].ex);
      if (vt[i].chk_en) begin
        chk($sformatf("v%0d_occ", i), occupancy, vt[i].occ);
        chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].ov);
        chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].ir);
        chk($sformatf("v%0d_wb", i), wb_out, vt[i].ewb);
        chk($sformatf("v%0d_m", i), m_out, vt[i].em);
        if (vt[i].chk_rs) chk($sformatf("v%0d_rs", i), rs_out, vt[i].ers);
        if (vt[i].zero)
          chk($sformatf("v%0d_zero", i),
              {pc_plus4_out, rd1_out, rd2_out, imm_out, rt_out, rd_out, ex_out}, 0);
      end
    end

    // Back-to-back stream of 8: one consumed per cycle.
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) drive(1, 0, 1, 1, $urandom, 2'($urandom), 2'($urandom), 4'($urandom));
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    chk("stream_throughput", pop_cnt - p0, 8);

    // Randomised traffic with occasional flush.
    for (int i = 0; i < 10000; i++)
      drive(1, ($urandom % 16) == 0, $urandom % 2, $urandom % 2, $urandom,
            2'($urandom), 2'($urandom), 4'($urandom));
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 0, 0, 0, 0);
    chk("drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
